fp_umadd_operand_collector: RTL and testbench
=============================================

Name: fp_umadd_operand_collector

Overview:
Upstream front-end for the floating-point multiply-add unit (p = a*c + b*d). It accepts one backpressured AXI4-Stream operand channel carrying 4-beat frames in the order a, b, c, d. It assembles each frame into a parallel operand group and issues that group with a single-cycle valid pulse, which is the form the non-backpressured multiply-add input expects. Malformed frames are detected, discarded and flagged.

Parameters:
DATA_WIDTH, 32, width of each floating-point operand word
CNT_WIDTH, 16, width of the issued-group counter

Ports:
i_aclk  in  1  clock
i_areset_n  in  1  asynchronous active-low reset
i_aclken  in  1  clock enable; all state, counters and outputs hold when low
i_axi4s_op_tdata  in  DATA_WIDTH  operand beat
i_axi4s_op_tvalid  in  1  beat valid
i_axi4s_op_tlast  in  1  marks the last beat of a frame
o_axi4s_op_tready  out  1  beat ready
o_axi4s_a_tdata  out  DATA_WIDTH  operand a of the issued group
o_axi4s_b_tdata  out  DATA_WIDTH  operand b
o_axi4s_c_tdata  out  DATA_WIDTH  operand c
o_axi4s_d_tdata  out  DATA_WIDTH  operand d
o_axi4s_tvalid  out  1  one-cycle issue pulse
o_frame_err  out  1  sticky malformed-frame flag
i_err_clr  in  1  synchronous clear for o_frame_err
o_group_cnt  out  CNT_WIDTH  number of issued groups; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, i_areset_n low):
  - FSM goes to S_A.
  - All operand outputs, o_axi4s_tvalid, o_frame_err and o_group_cnt go to 0.
  - o_axi4s_op_tready goes to 0 while reset is asserted.
- Beat acceptance: a beat is accepted when i_axi4s_op_tvalid & o_axi4s_op_tready & i_aclken are all high.
- o_axi4s_op_tready = i_aclken & reset-deasserted, in every state (S_A, S_B, S_C, S_D, S_FLUSH). Combinational from i_aclken; never depends on tvalid.
- FSM transitions, taken only on an accepted beat:
  - S_A: capture the beat into the a staging register.
    - tlast=0 -> S_B.
    - tlast=1 -> error, discard, stay in S_A.
  - S_B: capture into the b staging register.
    - tlast=0 -> S_C.
    - tlast=1 -> error, -> S_A.
  - S_C: capture into the c staging register.
    - tlast=0 -> S_D.
    - tlast=1 -> error, -> S_A.
  - S_D: capture d.
    - tlast=1 -> issue, -> S_A.
    - tlast=0 -> error, no issue, -> S_FLUSH.
  - S_FLUSH: drop beats.
    - tlast=1 -> S_A.
    - tlast=0 -> stay in S_FLUSH.
- Issue:
  - If d is accepted in cycle N, then in cycle N+1 the four staging words are copied to the o_axi4s_{a,b,c,d}_tdata outputs and o_axi4s_tvalid=1.
  - o_axi4s_tvalid stays high for exactly one enabled cycle, then returns to 0.
  - The operand outputs hold their last issued value until the next issue. They never change on discarded frames.
  - o_group_cnt increments in the same cycle o_axi4s_tvalid rises.
- Throughput:
  - The next frame's a beat may be accepted in cycle N+1, concurrently with the issue.
  - The staging registers are separate from the output registers, so no stall ever occurs.
  - Maximum rate is one group per 4 cycles.
- Error flag:
  - Any error event sets o_frame_err in the next enabled cycle.
  - i_err_clr clears it.
  - If an error event and i_err_clr occur in the same cycle, set wins.
  - Discarded partial frames leave both o_group_cnt and the operand outputs unchanged.
- i_aclken low:
  - tready is 0, no beat is accepted, and the FSM, registers and counters are frozen.
  - A pending issue pulse is deferred to the next enabled cycle. o_axi4s_tvalid is qualified so that it is high for exactly one enabled cycle.
- Counter wrap: 2^CNT_WIDTH-1 -> 0 on the next issue. No saturation.
- Reset mid-frame: partial staging data is discarded; after release, collection restarts in S_A.

Test Plan:
- Frame a=0x3F800000, b=0x40000000, c=0x40400000, d=0x40800000, tlast on the 4th beat -> one cycle after the d beat, outputs equal those four words, tvalid=1 for 1 cycle, o_group_cnt=1, o_frame_err=0.
- Three back-to-back frames with continuous tvalid -> tvalid pulses exactly 4 cycles apart, o_group_cnt=3, tready held at 1 throughout.
- tlast on the 2nd beat, followed by a good frame -> o_frame_err=1, no pulse for the bad frame, the good frame issues with correct values, o_group_cnt=1.
- 6-beat frame with tlast on the 6th beat -> o_frame_err=1, beats 5 and 6 are dropped, the next good frame issues correctly, and the outputs before that issue still hold the prior group.
- i_aclken toggled 1010 during a frame, and held low on the cycle after d -> the issue pulse is deferred to the next enabled cycle and lasts one enabled cycle. tready=0 whenever aclken=0.
- Preload o_group_cnt to 0xFFFF via 65535 frames, then one more frame -> count wraps to 0. Assert i_areset_n low after beat b of the next frame -> all outputs are 0, and the following full frame issues correctly.

Source files
------------

// File: rtl/fp_umadd_operand_collector.sv
// Collects the 4-beat a,b,c,d AXI4-Stream operand frames into one parallel group for the multiply-add unit.
// The group is issued with a one-cycle valid pulse. Malformed frames are dropped and flagged.
module fp_umadd_operand_collector #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  i_aclk,
   input  logic                  i_areset_n,
   input  logic                  i_aclken,
   input  logic [DATA_WIDTH-1:0] i_axi4s_op_tdata,
   input  logic                  i_axi4s_op_tvalid,
   input  logic                  i_axi4s_op_tlast,
   output logic                  o_axi4s_op_tready,
   output logic [DATA_WIDTH-1:0] o_axi4s_a_tdata,
   output logic [DATA_WIDTH-1:0] o_axi4s_b_tdata,
   output logic [DATA_WIDTH-1:0] o_axi4s_c_tdata,
   output logic [DATA_WIDTH-1:0] o_axi4s_d_tdata,
   output logic                  o_axi4s_tvalid,
   output logic                  o_frame_err,
   input  logic                  i_err_clr,
   output logic [CNT_WIDTH-1:0]  o_group_cnt
);

   typedef enum logic [2:0] {S_A, S_B, S_C, S_D, S_FLUSH} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_stg_a;
   logic [DATA_WIDTH-1:0] r_stg_b;
   logic [DATA_WIDTH-1:0] r_stg_c;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [DATA_WIDTH-1:0] r_c;
   logic [DATA_WIDTH-1:0] r_d;
   logic                  r_tvalid;
   logic                  r_frame_err;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic                  w_accept;
   logic                  w_err;
   logic                  w_issue;

   // Ready never waits on tvalid, so the source can stream without a bubble.
   assign o_axi4s_op_tready = i_aclken & i_areset_n;
   assign w_accept          = i_axi4s_op_tvalid & o_axi4s_op_tready;

   // Classify the accepted beat as frame completion or framing error.
   always_comb begin
      w_err   = 1'b0;
      w_issue = 1'b0;
      if (w_accept) begin
         case (r_state)
            S_A, S_B, S_C: w_err = i_axi4s_op_tlast;
            S_D: begin
               w_err   = ~i_axi4s_op_tlast;
               w_issue = i_axi4s_op_tlast;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state     <= S_A;
         r_stg_a     <= '0;
         r_stg_b     <= '0;
         r_stg_c     <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_d         <= '0;
         r_tvalid    <= 1'b0;
         r_frame_err <= 1'b0;
         r_cnt       <= '0;
      end else if (i_aclken) begin
         r_tvalid <= w_issue;
         // d goes straight to the output so the next a can be staged in the same cycle.
         if (w_issue) begin
            r_a   <= r_stg_a;
            r_b   <= r_stg_b;
            r_c   <= r_stg_c;
            r_d   <= i_axi4s_op_tdata;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
         if (w_err) begin
            r_frame_err <= 1'b1;
         end else if (i_err_clr) begin
            r_frame_err <= 1'b0;
         end
         if (w_accept) begin
            case (r_state)
               S_A: begin
                  if (!i_axi4s_op_tlast) begin
                     r_stg_a <= i_axi4s_op_tdata;
                     r_state <= S_B;
                  end
               end
               S_B: begin
                  r_stg_b <= i_axi4s_op_tdata;
                  r_state <= i_axi4s_op_tlast ? S_A : S_C;
               end
               S_C: begin
                  r_stg_c <= i_axi4s_op_tdata;
                  r_state <= i_axi4s_op_tlast ? S_A : S_D;
               end
               S_D:     r_state <= i_axi4s_op_tlast ? S_A : S_FLUSH;
               S_FLUSH: if (i_axi4s_op_tlast) r_state <= S_A;
               default: r_state <= S_A;
            endcase
         end
      end
   end

   assign o_axi4s_a_tdata = r_a;
   assign o_axi4s_b_tdata = r_b;
   assign o_axi4s_c_tdata = r_c;
   assign o_axi4s_d_tdata = r_d;
   // A pulse pending across a disabled cycle shows only once the clock enable returns.
   assign o_axi4s_tvalid  = r_tvalid & i_aclken;
   assign o_frame_err     = r_frame_err;
   assign o_group_cnt     = r_cnt;

endmodule

// File: tb/tb_fp_umadd_operand_collector.sv
// Scoreboard bench for fp_umadd_operand_collector: a reference model queues expected groups as beats are driven,
// and a monitor compares each issue pulse against that queue.
module tb_fp_umadd_operand_collector;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;   // narrow counter so the wrap is reached in a few hundred frames

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] c;
      logic [DW-1:0] d;
      logic [CW-1:0] cnt;
   } grp_t;

   logic          i_aclk = 1'b0;
   logic          i_areset_n;
   logic          i_aclken;
   logic [DW-1:0] i_tdata;
   logic          i_tvalid;
   logic          i_tlast;
   logic          i_err_clr;
   logic          o_tready;
   logic [DW-1:0] o_a, o_b, o_c, o_d;
   logic          o_tvalid;
   logic          o_frame_err;
   logic [CW-1:0] o_group_cnt;

   fp_umadd_operand_collector #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .i_aclk            (i_aclk),
      .i_areset_n        (i_areset_n),
      .i_aclken          (i_aclken),
      .i_axi4s_op_tdata  (i_tdata),
      .i_axi4s_op_tvalid (i_tvalid),
      .i_axi4s_op_tlast  (i_tlast),
      .o_axi4s_op_tready (o_tready),
      .o_axi4s_a_tdata   (o_a),
      .o_axi4s_b_tdata   (o_b),
      .o_axi4s_c_tdata   (o_c),
      .o_axi4s_d_tdata   (o_d),
      .o_axi4s_tvalid    (o_tvalid),
      .o_frame_err       (o_frame_err),
      .i_err_clr         (i_err_clr),
      .o_group_cnt       (o_group_cnt)
   );

   always #5 i_aclk = ~i_aclk;

   int            n_tests = 0;
   int            n_fail  = 0;
   grp_t          exp_q[$];
   int            seen_n  = 0;
   int            cyc     = 0;
   int            pulse_cyc[$];
   int            m_state = 0;
   logic [DW-1:0] m_a, m_b, m_c;
   logic [CW-1:0] m_cnt = '0;
   logic          m_err = 1'b0;
   grp_t          m_last = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model of the framing rules, advanced once per clock edge.
   task automatic model_step();
      logic err;
      err = 1'b0;
      if (i_aclken && i_areset_n) begin
         if (i_tvalid) begin
            case (m_state)
               0: if (i_tlast) err = 1'b1; else begin m_a = i_tdata; m_state = 1; end
               1: if (i_tlast) begin err = 1'b1; m_state = 0; end else begin m_b = i_tdata; m_state = 2; end
               2: if (i_tlast) begin err = 1'b1; m_state = 0; end else begin m_c = i_tdata; m_state = 3; end
               3: if (i_tlast) begin
                     m_cnt  = m_cnt + CW'(1);
                     m_last = '{a: m_a, b: m_b, c: m_c, d: i_tdata, cnt: m_cnt};
                     exp_q.push_back(m_last);
                     m_state = 0;
                  end else begin
                     err = 1'b1;
                     m_state = 4;
                  end
               default: if (i_tlast) m_state = 0;
            endcase
         end
         if (err) m_err = 1'b1;
         else if (i_err_clr) m_err = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge i_aclk);
      model_step();
      #1;
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic last);
      i_tvalid = 1'b1;
      i_tdata  = d;
      i_tlast  = last;
      tick();
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
   endtask

   task automatic frame(input logic [DW-1:0] a, b, c, d);
      beat(a, 1'b0);
      beat(b, 1'b0);
      beat(c, 1'b0);
      beat(d, 1'b1);
   endtask

   task automatic idle(input int n);
      i_tvalid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic check_outputs_hold(input string tag);
      check(tag, {o_a, o_b, o_c, o_d}, {m_last.a, m_last.b, m_last.c, m_last.d});
   endtask

   // Every enabled cycle: a pulse must appear exactly when a group is owed.
   task automatic monitor();
      grp_t e;
      logic due;
      forever begin
         @(negedge i_aclk);
         cyc++;
         if (i_areset_n && i_aclken) begin
            due = (exp_q.size() > seen_n);
            if (o_tvalid || due) begin
               check("issue_pulse", 128'(o_tvalid), 128'(due));
               if (due) begin
                  e = exp_q[seen_n];
                  seen_n++;
                  check("grp_a", 128'(o_a), 128'(e.a));
                  check("grp_b", 128'(o_b), 128'(e.b));
                  check("grp_c", 128'(o_c), 128'(e.c));
                  check("grp_d", 128'(o_d), 128'(e.d));
                  check("grp_cnt", 128'(o_group_cnt), 128'(e.cnt));
                  pulse_cyc.push_back(cyc);
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      i_areset_n = 1'b0;
      #2;
      check("rst_outs", {o_a, o_b, o_c, o_d}, 128'd0);
      check("rst_tvalid", 128'(o_tvalid), 128'd0);
      check("rst_err", 128'(o_frame_err), 128'd0);
      check("rst_cnt", 128'(o_group_cnt), 128'd0);
      check("rst_tready", 128'(o_tready), 128'd0);
      m_state = 0;
      m_cnt   = '0;
      m_err   = 1'b0;
      m_last  = '0;
      seen_n  = seen_n;
      tick();
      i_areset_n = 1'b1;
      tick();
   endtask

   initial begin
      int np;
      i_areset_n = 1'b0;
      i_aclken   = 1'b1;
      i_tdata    = '0;
      i_tvalid   = 1'b0;
      i_tlast    = 1'b0;
      i_err_clr  = 1'b0;
      fork monitor(); join_none
      #3;
      do_reset();

      // Single well-formed frame
      frame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      idle(2);
      check("t1_cnt", 128'(o_group_cnt), 128'd1);
      check("t1_err", 128'(o_frame_err), 128'd0);
      check("t1_tready", 128'(o_tready), 128'd1);

      // Three back-to-back frames, continuous tvalid
      np = pulse_cyc.size();
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 4; k++) begin
            beat($urandom, k == 3);
            i_tvalid = 1'b1;
            #1;
            check("b2b_tready", 128'(o_tready), 128'd1);
         end
      end
      i_tvalid = 1'b0;
      idle(2);
      check("b2b_pulses", 128'(pulse_cyc.size() - np), 128'd3);
      if (pulse_cyc.size() - np == 3) begin
         check("b2b_gap1", 128'(pulse_cyc[np+1] - pulse_cyc[np]), 128'd4);
         check("b2b_gap2", 128'(pulse_cyc[np+2] - pulse_cyc[np+1]), 128'd4);
      end
      check("b2b_cnt", 128'(o_group_cnt), 128'(m_cnt));
      check("b2b_cnt_abs", 128'(o_group_cnt), 128'd4);

      // Short frame (tlast on beat 2), then a good frame
      beat(32'h11111111, 1'b0);
      beat(32'h22222222, 1'b1);
      idle(1);
      check("short_err", 128'(o_frame_err), 128'(m_err));
      check("short_err_abs", 128'(o_frame_err), 128'd1);
      check_outputs_hold("short_hold");
      frame(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004);
      idle(2);
      check("short_cnt", 128'(o_group_cnt), 128'd5);

      // Clear, then clear coinciding with a new error: set wins
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      check("clr_err", 128'(o_frame_err), 128'd0);
      i_err_clr = 1'b1;
      beat(32'h5, 1'b1);
      i_err_clr = 1'b0;
      check("clr_vs_set", 128'(o_frame_err), 128'd1);
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;

      // 6-beat frame: beats 5,6 dropped; outputs keep previous group
      for (int k = 0; k < 6; k++) beat(32'hB0000000 + DW'(k), k == 5);
      idle(1);
      check("long_err", 128'(o_frame_err), 128'd1);
      check_outputs_hold("long_hold");
      check("long_cnt", 128'(o_group_cnt), 128'd5);
      frame(32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004);
      idle(2);
      check("long_next_cnt", 128'(o_group_cnt), 128'd6);

      // Clock enable toggled mid-frame and low right after d
      beat(32'hD0000001, 1'b0);
      i_aclken = 1'b0; i_tvalid = 1'b1; i_tdata = 32'hD0000002; #1;
      check("en_tready_low", 128'(o_tready), 128'd0);
      tick();
      i_aclken = 1'b1;
      beat(32'hD0000002, 1'b0);
      i_aclken = 1'b0; i_tvalid = 1'b1; i_tdata = 32'hD0000003; #1;
      check("en_tready_low2", 128'(o_tready), 128'd0);
      tick();
      i_aclken = 1'b1;
      beat(32'hD0000003, 1'b0);
      np = pulse_cyc.size();
      beat(32'hD0000004, 1'b1);
      i_aclken = 1'b0;
      #1;
      check("en_defer_low", 128'(o_tvalid), 128'd0);
      idle(2);
      check("en_no_pulse_yet", 128'(pulse_cyc.size() - np), 128'd0);
      i_aclken = 1'b1;
      idle(3);
      check("en_one_pulse", 128'(pulse_cyc.size() - np), 128'd1);

      // Drive the counter to all-ones, then one more frame wraps it
      for (int f = 0; f < 300 && m_cnt != {CW{1'b1}}; f++) frame($urandom, $urandom, $urandom, $urandom);
      idle(2);
      check("pre_wrap_cnt", 128'(o_group_cnt), 128'((1 << CW) - 1));
      frame(32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hE0000004);
      idle(2);
      check("wrap_cnt", 128'(o_group_cnt), 128'd0);

      // Reset after beat b, then a full frame
      beat(32'hF0000001, 1'b0);
      beat(32'hF0000002, 1'b0);
      do_reset();
      frame(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0);
      idle(2);
      check("post_rst_cnt", 128'(o_group_cnt), 128'd1);
      check("post_rst_a", 128'(o_a), 128'h12345678);
      check("post_rst_err", 128'(o_frame_err), 128'd0);

      idle(3);
      check("all_issued", 128'(seen_n), 128'(exp_q.size()));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
